// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment scan driver with frame-synchronous double-buffered loads.
// Optional leading-zero suppression is enabled by defining LZ_BLANK_EN.
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int BLANK_CYCLES   = 500,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] value;
      logic [NUM_DIGITS-1:0]   dp;
      logic [NUM_DIGITS-1:0]   en;
   } disp_t;

   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      unique case (nib)
         4'h0: hex_glyph = 7'b0111111;
         4'h1: hex_glyph = 7'b0000110;
         4'h2: hex_glyph = 7'b1011011;
         4'h3: hex_glyph = 7'b1001111;
         4'h4: hex_glyph = 7'b1100110;
         4'h5: hex_glyph = 7'b1101101;
         4'h6: hex_glyph = 7'b1111101;
         4'h7: hex_glyph = 7'b0000111;
         4'h8: hex_glyph = 7'b1111111;
         4'h9: hex_glyph = 7'b1101111;
         4'hA: hex_glyph = 7'b1110111;
         4'hB: hex_glyph = 7'b1111100;
         4'hC: hex_glyph = 7'b0111001;
         4'hD: hex_glyph = 7'b1011110;
         4'hE: hex_glyph = 7'b1111001;
         4'hF: hex_glyph = 7'b1110001;
      endcase
   endfunction

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   disp_t                 pend_q, pend_d;
   disp_t                 shadow_q, shadow_d;
   logic                  pend_flag_q, pend_flag_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  frame_start_q, frame_start_d;

   logic                  cnt_wrap, boundary;
   logic [NUM_DIGITS-1:0] show_en;
   logic [3:0]            cur_nib;
   logic                  cur_dp, cur_en;
   disp_t                 in_word;

`ifdef LZ_BLANK_EN
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  zero_above;

   // Digit i is a leading zero when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_above = zero_above && (shadow_q.value[4*i +: 4] == 4'h0);
         lz_mask[i] = zero_above;
      end
   end

   assign show_en = shadow_q.en & ~lz_mask;
`else
   assign show_en = shadow_q.en;
`endif

   assign in_word = '{value: value, dp: dp_in, en: digit_en};

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      cnt_wrap    = (cnt_q == CNT_LAST);
      boundary    = cnt_wrap && (idx_q == IDX_LAST);
      cnt_d       = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d       = idx_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      shadow_d    = shadow_q;

      if (cnt_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end

      // A load coinciding with the boundary bypasses the pending buffer.
      if (boundary) begin
         if (load) begin
            shadow_d = in_word;
         end else if (pend_flag_q) begin
            shadow_d = pend_q;
         end
         pend_flag_d = 1'b0;
      end else if (load) begin
         pend_d      = in_word;
         pend_flag_d = 1'b1;
      end

      cur_nib = '0;
      cur_dp  = 1'b0;
      cur_en  = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib = shadow_q.value[4*i +: 4];
            cur_dp  = shadow_q.dp[i];
            cur_en  = show_en[i];
         end
      end

      an_d = AN_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if ((idx_q == IDX_W'(i)) && cur_en && (cnt_q >= CNT_BLANK)) begin
            an_d[i] = ~AN_OFF[i];
         end
      end

      seg_d         = hex_glyph(cur_nib) ^ SEG_OFF;
      dp_d          = cur_dp ^ SEG_OFF[0];
      frame_start_d = boundary;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         idx_q         <= '0;
         pend_q        <= '0;
         shadow_q      <= '0;
         pend_flag_q   <= 1'b0;
         seg_q         <= SEG_OFF;
         dp_q          <= SEG_OFF[0];
         an_q          <= AN_OFF;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         pend_q        <= pend_d;
         shadow_q      <= shadow_d;
         pend_flag_q   <= pend_flag_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign seg         = seg_q;
   assign dp          = dp_q;
   assign an          = an_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 8-cycle digit period, 2 blank cycles, active-low.
// Expectations follow leading-zero suppression when compiled with LZ_BLANK_EN.
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        load;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_start;

   int errors = 0;
   int checks = 0;

`ifdef LZ_BLANK_EN
   localparam bit LZ_ON = 1'b1;
`else
   localparam bit LZ_ON = 1'b0;
`endif

   seg7_scan_driver #(
      .NUM_DIGITS    (4),
      .SCAN_DIV      (8),
      .BLANK_CYCLES  (2),
      .SEG_ACTIVE_LOW(1),
      .AN_ACTIVE_LOW (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value      (value),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .load       (load),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Lit-high glyphs straight from the hex glyph table.
   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'b0111111;
         4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;
         4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;
         4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;
         4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;
         4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;
         4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;
         4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;
         default: return 7'b1110001;
      endcase
   endfunction

   function automatic logic lz_off(input logic [15:0] v, input int d);
      logic all_zero;
      all_zero = 1'b1;
      for (int j = d; j < 4; j++) begin
         if (v[4*j +: 4] != 4'h0) all_zero = 1'b0;
      end
      return LZ_ON && (d > 0) && all_zero;
   endfunction

   // Walks one 32-cycle frame observing outputs at each falling edge; observation k
   // reflects cnt = k%8, idx = k/8. Optional loads are issued at observations la0/la1.
   task automatic run_frame(input string name,
                            input logic [15:0] ev, input logic [3:0] edp, input logic [3:0] een,
                            input int la0, input logic [15:0] lv0,
                            input int la1, input logic [15:0] lv1,
                            input logic [3:0] ldp, input logic [3:0] len);
      for (int k = 0; k < 32; k++) begin
         int         c;
         int         d;
         logic [3:0] exp_an;
         logic [6:0] exp_seg;
         logic       exp_dp;
         logic       exp_fs;
         @(negedge clk);
         c       = k % 8;
         d       = k / 8;
         exp_an  = 4'hF;
         if ((c >= 2) && een[d] && !lz_off(ev, d)) exp_an[d] = 1'b0;
         exp_seg = ~glyph(ev[4*d +: 4]);
         exp_dp  = ~edp[d];
         exp_fs  = (k == 31);
         check($sformatf("%s k%0d an", name, k), an, exp_an);
         check($sformatf("%s k%0d seg", name, k), seg, exp_seg);
         check($sformatf("%s k%0d dp", name, k), dp, exp_dp);
         check($sformatf("%s k%0d frame_start", name, k), frame_start, exp_fs);
         load = 1'b0;
         if (k == la0) begin
            load = 1'b1; value = lv0; dp_in = ldp; digit_en = len;
         end
         if (k == la1) begin
            load = 1'b1; value = lv1; dp_in = ldp; digit_en = len;
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      value    = 16'h0;
      dp_in    = 4'h0;
      digit_en = 4'h0;
      load     = 1'b0;

      repeat (2) @(negedge clk);
      check("reset seg", seg, 7'h7F);
      check("reset an", an, 4'hF);
      check("reset dp", dp, 1'b1);
      check("reset frame_start", frame_start, 1'b0);
      rst_n = 1'b1;

      // Empty shadow until the first boundary; 12AF is queued mid-frame.
      run_frame("f0_empty", 16'h0000, 4'h0, 4'h0, 5, 16'h12AF, -1, 16'h0, 4'h0, 4'hF);
      // 12AF displayed; a load of 0000 during digit 2 must not disturb this frame.
      run_frame("f1_12af", 16'h12AF, 4'h0, 4'hF, 17, 16'h0000, -1, 16'h0, 4'h0, 4'hF);
      // 0000 displayed; two loads in one frame, the last must win.
      run_frame("f2_0000", 16'h0000, 4'h0, 4'hF, 3, 16'h1111, 10, 16'h2222, 4'h0, 4'hF);
      // 2222 displayed; load lands exactly on the boundary cycle.
      run_frame("f3_2222", 16'h2222, 4'h0, 4'hF, 30, 16'h5A3C, -1, 16'h0, 4'h1, 4'h5);
      run_frame("f4_mask", 16'h5A3C, 4'h1, 4'h5, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);
      // No pending load, so the same content repeats; then queue 0030.
      run_frame("f5_hold", 16'h5A3C, 4'h1, 4'h5, 3, 16'h0030, -1, 16'h0, 4'h0, 4'hF);
      run_frame("f6_0030", 16'h0030, 4'h0, 4'hF, 7, 16'h0000, -1, 16'h0, 4'h0, 4'hF);
      run_frame("f7_zero", 16'h0000, 4'h0, 4'hF, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);

      // Reset in the middle of a lit digit period must blank outputs without a clock edge.
      repeat (4) @(negedge clk);
      check("pre-reset an lit", an, 4'hE);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset an", an, 4'hF);
      check("async reset seg", seg, 7'h7F);
      check("async reset dp", dp, 1'b1);
      check("async reset frame_start", frame_start, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      // Scan restarts from digit 0 with an empty shadow.
      run_frame("f8_after_reset", 16'h0000, 4'h0, 4'h0, -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed 7-segment display driver for NUM_DIGITS time-shared hex digits with common segment lines.
- Accepts a packed hex word plus per-digit decimal-point and enable masks.
- Decodes each nibble to segments, scans one anode per digit period, and inserts a ghosting-blank interval.
- Updates the displayed value only on frame boundaries, so a frame never mixes old and new digits.
- Sits between core debug/status registers and board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SCAN_DIV, 50000, clock cycles per digit period (>= 4)
BLANK_CYCLES, 500, cycles at start of each digit period with all anodes off (< SCAN_DIV)
SEG_ACTIVE_LOW, 1, 1: seg/dp driven low = lit; 0: high = lit
AN_ACTIVE_LOW, 1, 1: anode select low = on; 0: high = on

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
digit_en  in  NUM_DIGITS  1 = digit displayed, 0 = anode never asserted
load  in  1  single-cycle strobe; capture value/dp_in/digit_en
seg  out  7  segments {g,f,e,d,c,b,a}, bit0 = a, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
an  out  NUM_DIGITS  anode selects, polarity per AN_ACTIVE_LOW
frame_start  out  1  one-cycle pulse when digit index wraps to 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state:
  - cnt = 0, idx = 0.
  - pending, shadow, and pend_flag = 0.
  - seg and dp = all off for their polarity.
  - an = all off.
  - frame_start = 0.
- Period counter:
  - cnt counts 0..SCAN_DIV-1.
  - At cnt == SCAN_DIV-1: cnt <= 0 and idx <= idx+1. The increment wraps NUM_DIGITS-1 -> 0.
  - A boundary is the cycle where cnt == SCAN_DIV-1 and idx == NUM_DIGITS-1.
- Load path (double buffered):
  - On load outside a boundary cycle: pending <= {value, dp_in, digit_en}; pend_flag <= 1.
  - On a boundary cycle:
    - If load = 1, shadow <= inputs directly; pend_flag <= 0.
    - Else if pend_flag = 1, shadow <= pending; pend_flag <= 0.
  - A second load before the boundary overwrites pending. Only the last load wins.
  - Before the first boundary after reset, shadow = 0, so the display shows nothing (digit_en = 0).
- Decode uses the standard hex glyph table, lit-high form {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - Invert the result when SEG_ACTIVE_LOW = 1.
- Outputs are registered, so one cycle latency from (cnt, idx):
  - an[idx] is on iff cnt >= BLANK_CYCLES and shadow.digit_en[idx] = 1. All other anodes are off.
  - seg and dp carry the glyph of shadow digit idx in all cycles, including the blank interval.
  - frame_start = 1 in the cycle after the boundary.
- At most one anode is on in any cycle. No anode is on during blank cycles.
- Reset mid-frame: all outputs go off immediately, independent of clk. Scan restarts at digit 0.

Optional Feature:
Macro LZ_BLANK_EN, leading-zero suppression.
- Defined: digit i (i > 0) is treated as disabled (anode off) when digits i..NUM_DIGITS-1 of shadow value are all 0. Digit 0 is never suppressed, so value 0 shows a single "0". Suppression applies only where digit_en = 1.
- Undefined: all enabled digits are shown, including leading zeros. No extra logic is synthesised.

Test Plan:
- Use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, active-low.
- Reset release: seg=7'h7F, an=4'hF, frame_start=0. an stays 4'hF until the first boundary, since shadow is empty.
- load value=16'h12AF, dp_in=0, digit_en=4'hF:
  - After the next boundary, frame_start pulses.
  - Digit 0: 2 cycles an=1111, then 6 cycles an=1110 with seg=~7'b1110001.
  - Then digit 1 with an=1101 and glyph "A", and so on.
- Mid-frame load of 16'h0000 while digit 2 is shown: digits 2 and 3 of the current frame still show the old value. The new value appears only after frame_start.
- Two loads (16'h1111, then 16'h2222) in one frame: only 16'h2222 is displayed. A load on the boundary cycle itself is shown in the immediately following frame.
- digit_en=4'b0101, dp_in=4'b0001: an never drives digits 1 and 3 on. dp is lit only while digit 0 is displayed.
- With LZ_BLANK_EN, value=16'h0030: only digits 0 and 1 are driven on. With value=16'h0000, only digit 0 is on, showing "0". Assert rst_n low mid-period: an=4'hF asynchronously.
